// File: rtl/upcounter_2d.sv
// upcounter_2d: two-digit BCD up-counter with programmable limit, load and carry.
// Ports: clk clock; rst_n async active-high reset; enable count advance; load/load_val
// synchronous BCD load; limit BCD terminal value; bcd_t/bcd_u registered digits;
// ftsd_t/ftsd_u FTSD segment patterns; at_limit count >= limit; carry one-cycle pulse.
module FTSD_Decoder (
    input  logic [3:0]  bcd_i,
    output logic [14:0] ftsd_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    ftsd_o = 15'b0000_0011_1111_111;
            4'd1:    ftsd_o = 15'b1001_1111_1111_111;
            4'd2:    ftsd_o = 15'b0010_0101_1111_111;
            4'd3:    ftsd_o = 15'b0000_1101_1111_111;
            4'd4:    ftsd_o = 15'b1001_1001_1111_111;
            4'd5:    ftsd_o = 15'b0100_1001_1111_111;
            4'd6:    ftsd_o = 15'b0100_0001_1111_111;
            4'd7:    ftsd_o = 15'b0001_1111_1111_111;
            4'd8:    ftsd_o = 15'b0000_0001_1111_111;
            4'd9:    ftsd_o = 15'b0000_1001_1111_111;
            default: ftsd_o = 15'b1111_1111_1111_111;
        endcase
    end
endmodule

module upcounter_2d #(
    parameter bit WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [7:0]  load_val,
    input  logic [7:0]  limit,
    output logic [3:0]  bcd_t,
    output logic [3:0]  bcd_u,
    output logic [14:0] ftsd_t,
    output logic [14:0] ftsd_u,
    output logic        at_limit,
    output logic        carry
);
    function automatic logic [3:0] sat9(input logic [3:0] d);
        return d > 4'd9 ? 4'd9 : d;
    endfunction

    logic [7:0] cnt_q, cnt_d, limit_s, load_s, inc;
    logic       carry_q, carry_d;

    assign limit_s  = {sat9(limit[7:4]), sat9(limit[3:0])};
    assign load_s   = {sat9(load_val[7:4]), sat9(load_val[3:0])};
    // packed BCD compares correctly as plain binary since every nibble is <= 9
    assign at_limit = cnt_q >= limit_s;
    // only used below the limit, so the tens digit can never step past 9
    assign inc      = cnt_q[3:0] == 4'd9 ? {cnt_q[7:4] + 4'd1, 4'd0} : {cnt_q[7:4], cnt_q[3:0] + 4'd1};

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = 1'b0;
        if (load) begin
            cnt_d = load_s;
        end else if (enable && !at_limit) begin
            cnt_d   = inc;
            carry_d = !WRAP && inc == limit_s;
        end else if (enable && WRAP) begin
            cnt_d   = 8'h00;
            carry_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign bcd_t = cnt_q[7:4];
    assign bcd_u = cnt_q[3:0];
    assign carry = carry_q;

    FTSD_Decoder u_dec_t (.bcd_i(bcd_t), .ftsd_o(ftsd_t));
    FTSD_Decoder u_dec_u (.bcd_i(bcd_u), .ftsd_o(ftsd_u));
endmodule

// File: tb/tb_upcounter_2d.sv
// tb_upcounter_2d: checks WRAP=1 and WRAP=0 instances side by side.
module tb_upcounter_2d;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [7:0]  limit = 8'h59;
    logic [3:0]  t1, u1, t0, u0;
    logic [14:0] ft1, fu1, ft0, fu0;
    logic        at1, at0, cy1, cy0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [14:0] seg_tab [10];

    typedef struct {
        logic       ld;
        logic       en;
        logic [7:0] lv;
        logic [7:0] lm;
        logic [7:0] e1;
        logic       c1;
        logic [7:0] e0;
        logic       c0;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    upcounter_2d #(.WRAP(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_val(load_val), .limit(limit),
        .bcd_t(t1), .bcd_u(u1), .ftsd_t(ft1), .ftsd_u(fu1), .at_limit(at1), .carry(cy1)
    );
    upcounter_2d #(.WRAP(1'b0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_val(load_val), .limit(limit),
        .bcd_t(t0), .bcd_u(u0), .ftsd_t(ft0), .ftsd_u(fu0), .at_limit(at0), .carry(cy0)
    );

    function automatic int sat_dec(input logic [7:0] b);
        int hi, lo;
        hi = b[7:4] > 9 ? 9 : int'(b[7:4]);
        lo = b[3:0] > 9 ? 9 : int'(b[3:0]);
        return 10 * hi + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic check_state(input logic [7:0] e1, input logic c1, input logic [7:0] e0, input logic c0);
        int lim;
        lim = sat_dec(limit);
        chk("w1 bcd", {24'd0, t1, u1}, {24'd0, e1});
        chk("w1 carry", 32'(cy1), 32'(c1));
        chk("w1 at_limit", 32'(at1), 32'(sat_dec(e1) >= lim));
        chk("w1 ftsd_t", 32'(ft1), 32'(seg_tab[e1[7:4]]));
        chk("w1 ftsd_u", 32'(fu1), 32'(seg_tab[e1[3:0]]));
        chk("w0 bcd", {24'd0, t0, u0}, {24'd0, e0});
        chk("w0 carry", 32'(cy0), 32'(c0));
        chk("w0 at_limit", 32'(at0), 32'(sat_dec(e0) >= lim));
        chk("w0 ftsd_t", 32'(ft0), 32'(seg_tab[e0[7:4]]));
        chk("w0 ftsd_u", 32'(fu0), 32'(seg_tab[e0[3:0]]));
    endtask

    task automatic apply(input logic ld, input logic en, input logic [7:0] lv, input logic [7:0] lm);
        load = ld;
        enable = en;
        load_val = lv;
        limit = lm;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ld, input logic en, input logic [7:0] lv, input logic [7:0] lm,
                       input logic [7:0] e1, input logic c1, input logic [7:0] e0, input logic c0);
        vec_t v;
        v.ld = ld; v.en = en; v.lv = lv; v.lm = lm; v.e1 = e1; v.c1 = c1; v.e0 = e0; v.c0 = c0;
        vecs.push_back(v);
    endtask

    initial begin
        int mv[2];
        logic mc[2];
        logic ld, en;
        logic [7:0] lv, lm;
        int lim;
        seg_tab = '{15'b0000_0011_1111_111, 15'b1001_1111_1111_111, 15'b0010_0101_1111_111,
                    15'b0000_1101_1111_111, 15'b1001_1001_1111_111, 15'b0100_1001_1111_111,
                    15'b0100_0001_1111_111, 15'b0001_1111_1111_111, 15'b0000_0001_1111_111,
                    15'b0000_1001_1111_111};
        add(1, 0, 8'h58, 8'h59, 8'h58, 0, 8'h58, 0);
        add(0, 1, 8'h00, 8'h59, 8'h59, 0, 8'h59, 1);
        add(0, 1, 8'h00, 8'h59, 8'h00, 1, 8'h59, 0);
        add(0, 1, 8'h00, 8'h59, 8'h01, 0, 8'h59, 0);
        add(1, 0, 8'h21, 8'h23, 8'h21, 0, 8'h21, 0);
        add(0, 1, 8'h00, 8'h23, 8'h22, 0, 8'h22, 0);
        add(0, 1, 8'h00, 8'h23, 8'h23, 0, 8'h23, 1);
        add(0, 1, 8'h00, 8'h23, 8'h00, 1, 8'h23, 0);
        add(0, 1, 8'h00, 8'h23, 8'h01, 0, 8'h23, 0);
        add(0, 1, 8'h00, 8'h23, 8'h02, 0, 8'h23, 0);
        add(1, 1, 8'hA7, 8'h23, 8'h97, 0, 8'h97, 0);
        add(0, 0, 8'h00, 8'h3F, 8'h97, 0, 8'h97, 0);
        add(0, 1, 8'h00, 8'h3F, 8'h00, 1, 8'h97, 0);
        add(1, 0, 8'h98, 8'h99, 8'h98, 0, 8'h98, 0);
        add(0, 1, 8'h00, 8'h99, 8'h99, 0, 8'h99, 1);
        add(0, 0, 8'h00, 8'h99, 8'h99, 0, 8'h99, 0);
        add(0, 1, 8'h00, 8'h99, 8'h00, 1, 8'h99, 0);
        add(0, 0, 8'h00, 8'h99, 8'h00, 0, 8'h99, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h99, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h99, 0);
        add(1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0);
        add(0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;
        check_state(8'h00, 0, 8'h00, 0);
        rst_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            apply(0, 1, 8'h00, 8'h59);
            check_state(to_bcd(i), 0, to_bcd(i), 0);
        end
        foreach (vecs[i]) begin
            apply(vecs[i].ld, vecs[i].en, vecs[i].lv, vecs[i].lm);
            check_state(vecs[i].e1, vecs[i].c1, vecs[i].e0, vecs[i].c0);
        end

        apply(1, 0, 8'h36, 8'h37);
        apply(0, 1, 8'h00, 8'h37);
        check_state(8'h37, 0, 8'h37, 1);
        #3 rst_n = 1'b1;
        #1 check_state(8'h00, 0, 8'h00, 0);
        #1 rst_n = 1'b0;
        apply(0, 1, 8'h00, 8'h37);
        check_state(8'h01, 0, 8'h01, 0);

        rst_n = 1'b1;
        apply(0, 0, 8'h00, 8'h59);
        rst_n = 1'b0;
        mv = '{0, 0};
        mc = '{1'b0, 1'b0};
        lm = 8'h15;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom % 8) == 0;
            en = ($urandom % 4) != 0;
            lv = 8'($urandom);
            if (($urandom % 12) == 0) lm = 8'($urandom);
            lim = sat_dec(lm);
            for (int w = 0; w < 2; w++) begin
                mc[w] = 1'b0;
                if (ld) mv[w] = sat_dec(lv);
                else if (en && mv[w] < lim) begin
                    mv[w] = mv[w] + 1;
                    mc[w] = (w == 0) && (mv[w] == lim);
                end else if (en && w == 1) begin
                    mv[w] = 0;
                    mc[w] = 1'b1;
                end
            end
            apply(ld, en, lv, lm);
            check_state(to_bcd(mv[1]), mc[1], to_bcd(mv[0]), mc[0]);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/upcounter_2d.md
Name: upcounter_2d

Overview:
- Two-digit BCD up-counter (00..limit) with programmable terminal value, synchronous load, and a carry pulse for cascading stages.
- Drives two 15-bit FTSD segment patterns through FTSD_Decoder instances, one per digit.
- Counterpart to the 2-digit down-counter. Used for stopwatch/elapsed-time displays, and as the minutes/seconds stages of timers counting upward.

Parameters:
- WRAP, 1: 1 = wrap to 00 after limit with carry; 0 = saturate at limit.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-high
- enable  input  1  count-advance qualifier, sampled on clk
- load  input  1  synchronous load strobe
- load_val  input  8  packed BCD load value {tens, units}
- limit  input  8  packed BCD terminal value {tens, units}
- bcd_t  output  4  tens digit, registered
- bcd_u  output  4  units digit, registered
- ftsd_t  output  15  FTSD pattern of bcd_t (FTSD_Decoder)
- ftsd_u  output  15  FTSD pattern of bcd_u (FTSD_Decoder)
- at_limit  output  1  combinational: count >= limit
- carry  output  1  registered one-cycle pulse, see below

Behaviour:
- Reset (rst_n=1, asynchronous): bcd_t=0, bcd_u=0, carry=0. Held while rst_n=1. ftsd_* reflect 0.
- Priority per clk edge: reset > load > enable > hold.
- Digit sanitising: any load_val or limit nibble >9 is treated as 9. The counter never holds a nibble >9.
- Compare: count and limit are compared as packed 8-bit values after sanitising. at_limit = ({bcd_t,bcd_u} >= limit_s).
- load=1: {bcd_t,bcd_u} <= sanitised load_val, carry <= 0. The enable value in the same cycle is ignored.
- enable=0, load=0: count holds, carry <= 0.
- enable=1, load=0, at_limit=0: increment.
  - bcd_u<9: bcd_u+1.
  - bcd_u==9: bcd_u<=0, bcd_t<=bcd_t+1.
  - carry <= 0, except in WRAP=0 mode when the new count equals limit_s, where carry <= 1.
- enable=1, load=0, at_limit=1:
  - WRAP=1: count <= 00, carry <= 1. Carry is high in the same cycle the outputs show 00.
  - WRAP=0: count holds, carry <= 0.
- Count above limit (after a load or a limit change) behaves as at_limit: wraps to 00 (WRAP=1) or freezes (WRAP=0). It never counts past 99.
- limit=00:
  - WRAP=1: count stays 00, carry=1 on every enabled cycle.
  - WRAP=0: count stays 00, carry never asserts.
- limit may change any cycle. It takes effect in the same cycle's comparison, with no pipeline.
- Latency: enable or load to new bcd_*: 1 clk. bcd_* to ftsd_*: combinational.
- Reset mid-count: immediate return to 00, carry=0. The first enabled edge after release gives 01.
- Cascading: the upper stage's enable = lower stage carry. With WRAP=1 this gives exactly one upper increment per lower rollover.

Test Plan:
1. Reset and count: rst_n pulse, WRAP=1, limit=59, enable=1 for 12 clks. Required: bcd 00→12, the 09→10 transition is correct, carry=0 throughout, ftsd_u/ftsd_t match FTSD_Decoder for each digit.
2. Wrap at limit: load 58, limit=59, WRAP=1, enable=1 for 3 clks. Required: 59 (at_limit=1), then 00 with carry=1 for exactly one cycle, then 01 with carry=0.
3. Saturate: WRAP=0, limit=23, load 21, enable=1 for 5 clks. Required: 22, then 23 with carry=1, then hold at 23 with carry=0 and at_limit=1.
4. Load precedence and sanitising: load=1 and enable=1 together with load_val=8'hA7. Required: bcd_t=9, bcd_u=7 next cycle, no increment, carry=0. Then limit=8'h3F gives effective limit 39: at_limit=1 and the next enable wraps to 00 (WRAP=1).
5. Enable gating and 99 boundary: limit=99, load 98, alternate enable 1/0 for 4 clks. Required: 99, hold, 00 with carry=1, hold with carry=0.
6. Async reset mid-count: assert rst_n between clk edges at count 37. Required: outputs 00 before the next clk edge, carry=0. After release with enable=1: 01.
